computer_system_audio_dac_tx: RTL and testbench

//  Avalon-MM slave that accepts left/right DAC samples from the CPU, buffers them as stereo pairs
//  in a small FIFO and serializes them onto the codec's I2S DAC data line. Transmit counterpart
//  of the audio ADC input ports; codec is I2S master (supplies BCLK and DACLRCK), this block drives DACDAT.

---
 rtl/computer_system_audio_pkg.sv | 20 ++
 rtl/computer_system_audio_dac_fifo.sv | 57 +++++
 rtl/computer_system_audio_dac_tx.sv | 180 ++++++++++++++++++
 tb/tb_computer_system_audio_dac_tx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/computer_system_audio_pkg.sv
// rtl/computer_system_audio_pkg.sv - register map, bit positions and serializer states for the audio DAC
package computer_system_audio_pkg;
    localparam logic [1:0] ADDR_LEFT    = 2'd0;
    localparam logic [1:0] ADDR_RIGHT   = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;
    localparam logic [1:0] ADDR_CONTROL = 2'd3;

    localparam int STATUS_UNDERRUN_BIT = 8;
    localparam int STATUS_OVERFLOW_BIT = 9;

    localparam int CTRL_ENABLE_BIT       = 0;
    localparam int CTRL_CLR_UNDERRUN_BIT = 1;
    localparam int CTRL_CLR_OVERFLOW_BIT = 2;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        RUN        = 2'd2
    } tx_state_t;
endpackage

// File: rtl/computer_system_audio_dac_fifo.sv
// rtl/computer_system_audio_dac_fifo.sv - single-clock show-ahead FIFO holding stereo sample pairs
module computer_system_audio_dac_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == FULL_LEVEL);
    // A pop from empty is ignored; a push into a full FIFO only lands if a pop frees a slot.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/computer_system_audio_dac_tx.sv
// rtl/computer_system_audio_dac_tx.sv - register slave feeding stereo pairs to an I2S DAC serializer
module computer_system_audio_dac_tx
    import computer_system_audio_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        aud_bclk,
    input  logic        aud_daclrck,
    output logic        aud_dacdat
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] SLOT_BITS = CW'(DATA_WIDTH);

    logic                    wr_en;
    logic                    enable;
    logic                    underrun;
    logic                    overflow;
    logic [DATA_WIDTH-1:0]   left_hold;
    logic [DATA_WIDTH-1:0]   shreg;
    logic [DATA_WIDTH-1:0]   rbuf;
    logic [CW-1:0]           bit_cnt;
    logic [1:0]              bclk_sync;
    logic [1:0]              lrck_sync;
    logic                    bclk_last;
    logic                    lrck_prev;
    logic                    bclk_fall;
    logic                    left_start;
    logic                    right_start;
    logic                    frame_load;
    logic                    push;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [LW-1:0]           fifo_level;
    logic [2*DATA_WIDTH-1:0] fifo_dout;
    logic [31:0]             rd_mux;
    logic                    unused_wdata;
    tx_state_t               state;
    tx_state_t               state_next;

    assign wr_en        = chipselect && !write_n;
    assign push         = wr_en && (address == ADDR_RIGHT);
    assign unused_wdata = ^writedata[31:DATA_WIDTH];

    computer_system_audio_dac_fifo #(
        .WIDTH (2 * DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .din     ({left_hold, writedata[DATA_WIDTH-1:0]}),
        .pop     (frame_load),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_STATUS: begin
                rd_mux[7:0]                 = {{(8-LW){1'b0}}, fifo_level};
                rd_mux[STATUS_UNDERRUN_BIT] = underrun;
                rd_mux[STATUS_OVERFLOW_BIT] = overflow;
            end
            ADDR_CONTROL: rd_mux[CTRL_ENABLE_BIT] = enable;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata  <= '0;
            left_hold <= '0;
            enable    <= 1'b0;
            underrun  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            readdata <= rd_mux;
            if (wr_en && address == ADDR_LEFT) begin
                left_hold <= writedata[DATA_WIDTH-1:0];
            end
            if (wr_en && address == ADDR_CONTROL) begin
                enable <= writedata[CTRL_ENABLE_BIT];
                if (writedata[CTRL_CLR_UNDERRUN_BIT]) underrun <= 1'b0;
                if (writedata[CTRL_CLR_OVERFLOW_BIT]) overflow <= 1'b0;
            end
            // Flag sets come after the clears so a same-cycle event is not lost.
            if (frame_load && fifo_empty) underrun <= 1'b1;
            if (push && fifo_full && !frame_load) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            bclk_last <= 1'b0;
            lrck_prev <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[0], aud_bclk};
            lrck_sync <= {lrck_sync[0], aud_daclrck};
            bclk_last <= bclk_sync[1];
            if (bclk_fall) lrck_prev <= lrck_sync[1];
        end
    end

    assign bclk_fall   = bclk_last && !bclk_sync[1];
    assign left_start  = bclk_fall && lrck_prev && !lrck_sync[1];
    assign right_start = bclk_fall && !lrck_prev && lrck_sync[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        frame_load = 1'b0;
        case (state)
            IDLE: if (enable) state_next = WAIT_FRAME;
            WAIT_FRAME: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (left_start) begin
                    state_next = RUN;
                    frame_load = 1'b1;
                end
            end
            RUN: begin
                if (left_start) begin
                    if (enable) frame_load = 1'b1;
                    else        state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Each slot starts with the I2S one-bit delay, then the sample MSB-first, then zero padding.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            aud_dacdat <= 1'b0;
            shreg      <= '0;
            rbuf       <= '0;
            bit_cnt    <= '0;
        end else if (frame_load) begin
            aud_dacdat <= 1'b0;
            bit_cnt    <= SLOT_BITS;
            shreg      <= fifo_empty ? '0 : fifo_dout[2*DATA_WIDTH-1:DATA_WIDTH];
            rbuf       <= fifo_empty ? '0 : fifo_dout[DATA_WIDTH-1:0];
        end else if (state != RUN) begin
            aud_dacdat <= 1'b0;
        end else if (bclk_fall) begin
            if (left_start) begin
                aud_dacdat <= 1'b0;
            end else if (right_start) begin
                aud_dacdat <= 1'b0;
                bit_cnt    <= SLOT_BITS;
                shreg      <= rbuf;
            end else if (bit_cnt != '0) begin
                aud_dacdat <= shreg[DATA_WIDTH-1];
                shreg      <= shreg << 1;
                bit_cnt    <= bit_cnt - 1'b1;
            end else begin
                aud_dacdat <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_computer_system_audio_dac_tx.sv
// tb/tb_computer_system_audio_dac_tx.sv - self-checking bench with codec clock generator and frame model
module tb_computer_system_audio_dac_tx;
    import computer_system_audio_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        aud_bclk;
    logic        aud_daclrck;
    logic        aud_dacdat;

    computer_system_audio_dac_tx #(.DATA_WIDTH(24), .FIFO_DEPTH(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .address     (address),
        .chipselect  (chipselect),
        .write_n     (write_n),
        .writedata   (writedata),
        .readdata    (readdata),
        .aud_bclk    (aud_bclk),
        .aud_daclrck (aud_daclrck),
        .aud_dacdat  (aud_dacdat)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int pos;

    // Behavioural model: queue of stereo pairs, sticky flags, and the pair owned by the current frame.
    logic [23:0] m_left = '0;
    logic [47:0] m_q[$];
    bit          m_en = 0, m_unr = 0, m_ovf = 0;
    bit          f_active = 0;
    logic [23:0] f_l = '0, f_r = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_left = '0; m_en = 0; m_unr = 0; m_ovf = 0; f_active = 0;
    endtask

    task automatic frame_start();
        logic [47:0] p;
        f_active = m_en;
        if (m_en) begin
            if (m_q.size() == 0) begin
                p = '0;
                m_unr = 1;
            end else begin
                p = m_q.pop_front();
            end
            f_l = p[47:24];
            f_r = p[23:0];
        end
    endtask

    function automatic logic exp_bit(input int p);
        if (!f_active)          return 1'b0;
        if (p >= 1 && p <= 24)  return f_l[24 - p];
        if (p >= 33 && p <= 56) return f_r[56 - p];
        return 1'b0;
    endfunction

    // Codec: BCLK = clk/8, 32 BCLK per slot; LRCK changes on falling BCLK; output sampled at rising BCLK.
    initial begin
        aud_bclk = 1'b1; aud_daclrck = 1'b1; pos = 63;
        #3;
        forever begin
            #40;
            aud_bclk = 1'b0;
            pos = (pos + 1) % 64;
            aud_daclrck = (pos >= 32);
            if (pos == 0) frame_start();
            #40;
            aud_bclk = 1'b1;
            check($sformatf("dacdat_pos%0d", pos), {31'b0, aud_dacdat}, {31'b0, exp_bit(pos)});
        end
    end

    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
        case (a)
            ADDR_LEFT:  m_left = d[23:0];
            ADDR_RIGHT: if (m_q.size() == 8) m_ovf = 1; else m_q.push_back({m_left, d[23:0]});
            ADDR_CONTROL: begin
                m_en = d[0];
                if (d[1]) m_unr = 0;
                if (d[2]) m_ovf = 0;
            end
            default: ;
        endcase
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        @(posedge clk);
        #1 d = readdata;
    endtask

    task automatic check_status(input string name);
        logic [31:0] d;
        reg_read(ADDR_STATUS, d);
        check(name, d, {22'b0, m_ovf, m_unr, 8'(m_q.size())});
    endtask

    task automatic wait_next_pos(input int target);
        int cyc = 0;
        while (pos == target && cyc < 1500) begin @(posedge clk); cyc++; end
        while (pos != target && cyc < 1500) begin @(posedge clk); cyc++; end
        check($sformatf("wait_pos%0d_in_time", target), {31'b0, cyc < 1500}, 32'h1);
    endtask

    typedef struct packed {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [14];
    logic [31:0] d;
    logic [31:0] ctrl;
    int          n_pairs;

    initial begin
        vecs[0]  = '{1'b0, ADDR_STATUS,  32'h0,        32'h0};
        vecs[1]  = '{1'b0, ADDR_CONTROL, 32'h0,        32'h0};
        vecs[2]  = '{1'b1, ADDR_CONTROL, 32'h1,        32'h0};
        vecs[3]  = '{1'b0, ADDR_CONTROL, 32'h0,        32'h1};
        vecs[4]  = '{1'b1, ADDR_CONTROL, 32'h0,        32'h0};
        vecs[5]  = '{1'b0, ADDR_CONTROL, 32'h0,        32'h0};
        vecs[6]  = '{1'b1, ADDR_LEFT,    32'hFFABCDEF, 32'h0};
        vecs[7]  = '{1'b0, ADDR_LEFT,    32'h0,        32'h0};
        vecs[8]  = '{1'b1, ADDR_RIGHT,   32'h00123456, 32'h0};
        vecs[9]  = '{1'b0, ADDR_RIGHT,   32'h0,        32'h0};
        vecs[10] = '{1'b0, ADDR_STATUS,  32'h0,        32'h1};
        vecs[11] = '{1'b1, ADDR_CONTROL, 32'h6,        32'h0};
        vecs[12] = '{1'b0, ADDR_STATUS,  32'h0,        32'h1};
        vecs[13] = '{1'b0, ADDR_CONTROL, 32'h0,        32'h0};

        chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_readdata", readdata, 32'h0);
        check("reset_dacdat", {31'b0, aud_dacdat}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        reg_read(ADDR_STATUS, d);
        check("reset_status", d, 32'h0);

        wait_next_pos(40);
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].wr) begin
                reg_write(vecs[i].addr, vecs[i].data);
            end else begin
                reg_read(vecs[i].addr, d);
                check($sformatf("vec%0d", i), d, vecs[i].exp);
            end
        end

        // Enable mid right slot: first pair appears only from the next left frame start.
        reg_write(ADDR_CONTROL, 32'h1);
        wait_next_pos(40);
        reg_read(ADDR_STATUS, d);
        check("level_after_first_frame", d, 32'h0);
        wait_next_pos(40);
        reg_read(ADDR_STATUS, d);
        check("underrun_status", d, 32'h100);
        reg_write(ADDR_CONTROL, 32'h3);
        reg_read(ADDR_STATUS, d);
        check("underrun_cleared", d, 32'h0);

        // Right-only writes reuse the held left sample.
        reg_write(ADDR_LEFT, 32'h7FFFFF);
        reg_write(ADDR_RIGHT, 32'h1);
        reg_write(ADDR_RIGHT, 32'h2);
        wait_next_pos(40);
        wait_next_pos(40);
        check_status("status_after_right_only");

        for (int it = 0; it < 6; it++) begin
            wait_next_pos(40);
            n_pairs = $urandom_range(0, 3);
            for (int k = 0; k < n_pairs; k++) begin
                if ($urandom_range(0, 1) == 1) reg_write(ADDR_LEFT, $urandom());
                reg_write(ADDR_RIGHT, $urandom());
            end
            ctrl = {29'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0};
            reg_write(ADDR_CONTROL, ctrl);
            check_status($sformatf("rand_status%0d", it));
        end

        // Reset in the middle of a left data word.
        wait_next_pos(40);
        reg_write(ADDR_LEFT, 32'hFFFFFF);
        reg_write(ADDR_RIGHT, 32'hFFFFFF);
        reg_write(ADDR_CONTROL, 32'h1);
        wait_next_pos(10);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("midword_reset_dacdat", {31'b0, aud_dacdat}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("midword_reset_readdata", readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        reg_read(ADDR_STATUS, d);
        check("status_after_midword_reset", d, 32'h0);

        // Nine pushes into an eight-deep FIFO; the ninth pair must never reach the wire.
        wait_next_pos(40);
        for (int i = 0; i < 9; i++) begin
            reg_write(ADDR_LEFT, $urandom());
            reg_write(ADDR_RIGHT, $urandom());
        end
        reg_read(ADDR_STATUS, d);
        check("overflow_status", d, 32'h208);
        reg_write(ADDR_CONTROL, 32'h1);
        for (int f = 0; f < 10; f++) wait_next_pos(40);
        reg_read(ADDR_STATUS, d);
        check("drained_status", d, 32'h300);
        check_status("drained_status_model");

        reg_write(ADDR_CONTROL, 32'h6);
        wait_next_pos(40);
        wait_next_pos(40);
        check_status("final_status");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
